// File: rtl/sbox_pipe_if.sv
// sbox_pipe_if: valid/ready input and output channels of the S-box pipeline
interface sbox_pipe_if #(parameter int LANES = 4);
  logic               in_valid;
  logic               in_ready;
  logic [8*LANES-1:0] in_data;
  logic               in_inv;
  logic               out_valid;
  logic               out_ready;
  logic [8*LANES-1:0] out_data;
  logic               out_inv;
  modport master (output in_valid, in_data, in_inv, out_ready, input in_ready, out_valid, out_data, out_inv);
  modport slave (input in_valid, in_data, in_inv, out_ready, output in_ready, out_valid, out_data, out_inv);
endinterface

// File: rtl/sbox_pipe.sv
// sbox_pipe: two-stage elastic AES forward/inverse S-box pipeline over LANES byte lanes
module sbox_pipe #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  sbox_pipe_if.slave       bus,
  output logic [CNT_W-1:0] xfer_cnt
);
  localparam logic [2047:0] FWD_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  logic               s1_valid_q, s1_valid_d, s1_inv_q, s1_inv_d;
  logic               s2_valid_q, s2_valid_d, s2_inv_q, s2_inv_d;
  logic [8*LANES-1:0] s1_data_q, s1_data_d, s2_data_q, s2_data_d, sub;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               adv1, adv2;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign sub[8*k +: 8] = s1_inv_q ? INV_SBOX[{~s1_data_q[8*k +: 8], 3'b000} +: 8]
                                    : FWD_SBOX[{~s1_data_q[8*k +: 8], 3'b000} +: 8];
  end
  // stage advance decode and next-state for both stages and the transfer counter
  always_comb begin
    adv2       = !s2_valid_q || bus.out_ready;
    adv1       = !s1_valid_q || adv2;
    s1_valid_d = adv1 ? bus.in_valid : s1_valid_q;
    s1_data_d  = (adv1 && bus.in_valid) ? bus.in_data : s1_data_q;
    s1_inv_d   = (adv1 && bus.in_valid) ? bus.in_inv : s1_inv_q;
    s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
    s2_data_d  = (adv2 && s1_valid_q) ? sub : s2_data_q;
    s2_inv_d   = (adv2 && s1_valid_q) ? s1_inv_q : s2_inv_q;
    cnt_d      = cnt_q + CNT_W'(s2_valid_q && bus.out_ready);
  end
  // pipeline and counter registers; data is cleared too so the port never shows X
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_inv_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_inv_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_inv_q   <= s1_inv_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_inv_q   <= s2_inv_d;
      cnt_q      <= cnt_d;
    end
  end
  assign bus.in_ready  = adv1;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_inv   = s2_inv_q;
  assign xfer_cnt      = cnt_q;
endmodule

// File: tb/tb_sbox_pipe.sv
// tb_sbox_pipe: directed and streaming checks of sbox_pipe against an arithmetic S-box model
module tb_sbox_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cnt0, cnt2;
  logic [3:0]  cnt1;
  int          n_tests = 0, n_fail = 0;
  logic [7:0]  model_s [256];
  logic [7:0]  src [256];
  logic [7:0]  expb [256];
  logic [7:0]  got [256];
  logic [31:0] tv_in [3] = '{32'h00010203, 32'h10111213, 32'h20212223};
  logic [31:0] tv_out [3] = '{32'h637c777b, 32'hca82c97d, 32'hb7fd9326};

  sbox_pipe_if #(.LANES(4)) a();
  sbox_pipe_if #(.LANES(4)) b();
  sbox_pipe_if #(.LANES(1)) c();

  sbox_pipe #(.LANES(4), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .bus(a.slave), .xfer_cnt(cnt0));
  sbox_pipe #(.LANES(4), .CNT_W(4))  u1 (.clk(clk), .rst(rst), .bus(b.slave), .xfer_cnt(cnt1));
  sbox_pipe #(.LANES(1), .CNT_W(16)) u2 (.clk(clk), .rst(rst), .bus(c.slave), .xfer_cnt(cnt2));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p = 8'h00, u = x, v = y;
    for (int i = 0; i < 8; i++) begin
      if (v[0]) p = p ^ u;
      u = {u[6:0], 1'b0} ^ (u[7] ? 8'h1b : 8'h00);
      v = v >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] q = 8'h00;
    for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) q = 8'(y);
    return q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
  endfunction

  task automatic run_pass(input logic inv);
    int sent = 0, rcvd = 0, cyc = 0;
    while (rcvd < 256 && cyc < 4000) begin
      a.in_valid  = (sent < 256) && ($urandom_range(0, 7) != 0);
      a.in_data   = {4{src[sent < 256 ? sent : 0]}};
      a.in_inv    = inv;
      a.out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      if (a.out_valid && a.out_ready) begin
        check("stream", {a.out_inv, a.out_data}, {inv, {4{expb[rcvd]}}});
        got[rcvd] = a.out_data[7:0];
        rcvd++;
      end
      if (a.in_valid && a.in_ready) sent++;
      tick();
      cyc++;
    end
    a.in_valid = 1'b0;
    check("stream_done", 64'(rcvd), 64'd256);
  endtask

  initial begin
    int acc;
    int seen;
    logic [31:0] held;
    for (int i = 0; i < 256; i++) model_s[i] = sbox_model(8'(i));
    a.in_valid = 0; a.in_data = '0; a.in_inv = 0; a.out_ready = 1;
    b.in_valid = 0; b.in_data = '0; b.in_inv = 0; b.out_ready = 1;
    c.in_valid = 0; c.in_data = '0; c.in_inv = 0; c.out_ready = 1;
    tick();
    tick();
    check("rst_out_valid", a.out_valid, 0);
    check("rst_out_data", a.out_data, 0);
    check("rst_out_inv", a.out_inv, 0);
    check("rst_cnt", cnt0, 0);
    check("rst_in_ready", a.in_ready, 1);
    rst = 0;
    a.in_valid = 1; a.in_data = 32'hFF530100; a.in_inv = 0;
    tick();
    a.in_valid = 0;
    tick();
    check("fwd_valid", a.out_valid, 1);
    check("fwd_data", {a.out_inv, a.out_data}, {1'b0, 32'h16ED7C63});
    tick();
    check("fwd_cnt", cnt0, 1);
    check("fwd_drained", a.out_valid, 0);
    a.in_valid = 1; a.in_data = 32'h16ED7C63; a.in_inv = 1;
    tick();
    a.in_valid = 0;
    tick();
    check("inv_valid", a.out_valid, 1);
    check("inv_data", {a.out_inv, a.out_data}, {1'b1, 32'hFF530100});
    tick();
    check("inv_cnt", cnt0, 2);
    a.in_inv = 0;
    for (int t = 0; t < 5; t++) begin
      a.in_valid = t < 3;
      a.in_data  = tv_in[t < 3 ? t : 0];
      @(negedge clk);
      if (t < 3) check("tput_ready", a.in_ready, 1);
      if (t >= 2) check("tput_out", {a.out_valid, a.out_data}, {1'b1, tv_out[t-2]});
      tick();
    end
    check("tput_cnt", cnt0, 5);
    a.out_ready = 0;
    acc = 0;
    for (int t = 0; t < 6; t++) begin
      a.in_valid = 1;
      a.in_data  = acc == 0 ? 32'h00000000 : acc == 1 ? 32'hFFFFFFFF : 32'h01010101;
      @(negedge clk);
      if (t == 2) held = a.out_data;
      if (a.in_valid && a.in_ready) acc++;
      tick();
    end
    check("stall_accepted", 64'(acc), 2);
    check("stall_ready", a.in_ready, 0);
    check("stall_valid", a.out_valid, 1);
    check("stall_hold", a.out_data, held);
    check("stall_data", a.out_data, 32'h63636363);
    a.in_valid = 0; a.out_ready = 1;
    @(negedge clk);
    check("drain0", {a.out_valid, a.out_data}, {1'b1, 32'h63636363});
    tick();
    @(negedge clk);
    check("drain1", {a.out_valid, a.out_data}, {1'b1, 32'h16161616});
    tick();
    check("drain_empty", a.out_valid, 0);
    check("drain_cnt", cnt0, 7);
    a.out_ready = 0; a.in_valid = 1; a.in_data = 32'h01010101;
    tick();
    a.in_data = 32'h02020202;
    tick();
    check("full_ready", a.in_ready, 0);
    rst = 1;
    tick();
    rst = 0; a.in_valid = 0; a.out_ready = 1;
    check("mid_rst_valid", a.out_valid, 0);
    check("mid_rst_data", a.out_data, 0);
    check("mid_rst_cnt", cnt0, 0);
    check("mid_rst_ready", a.in_ready, 1);
    seen = 0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (a.out_valid) seen++;
      tick();
    end
    check("no_stale", 64'(seen), 0);
    for (int i = 0; i < 256; i++) begin
      src[i]  = 8'(i);
      expb[i] = model_s[i];
    end
    run_pass(1'b0);
    for (int i = 0; i < 256; i++) begin
      src[i]  = got[i];
      expb[i] = 8'(i);
    end
    run_pass(1'b1);
    a.out_ready = 1;
    check("stream_cnt", cnt0, 512);
    for (int i = 0; i < 17; i++) begin
      b.in_valid = 1;
      b.in_data  = {4{8'(i)}};
      tick();
    end
    b.in_valid = 0;
    tick();
    tick();
    tick();
    check("wrap_cnt", cnt1, 1);
    c.in_valid = 1; c.in_data = 8'h00; c.in_inv = 0;
    tick();
    c.in_valid = 0;
    tick();
    check("lane1_out", {c.out_valid, c.out_inv, c.out_data}, {2'b10, 8'h63});
    tick();
    check("lane1_cnt", cnt2, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sbox_pipe.md
SBOX_PIPE -- requirements
Module: sbox_pipe

Interface
REQ-001 Parameter LANES, default 4, is the number of independent byte lanes processed per transfer; legal range 1..16.
REQ-002 Parameter CNT_W, default 16, is the width of the completed-transfer counter.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  is the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port in_valid  input  1  indicates that in_data and in_inv hold a transfer.
REQ-006 Port in_ready  output  1  indicates that the block accepts a transfer this cycle.
REQ-007 Port in_data  input  8*LANES  carries input bytes; lane k occupies bits [8k+7:8k].
REQ-008 Port in_inv  input  1  selects the mode: 0 = forward AES S-box, 1 = inverse AES S-box; it is captured per transfer.
REQ-009 Port out_valid  output  1  indicates that out_data holds a result.
REQ-010 Port out_ready  input  1  indicates that the downstream consumer accepts the result.
REQ-011 Port out_data  output  8*LANES  carries the substituted bytes, using the same lane mapping as in_data.
REQ-012 Port out_inv  output  1  returns the mode bit of the transfer currently on out_data.
REQ-013 Port xfer_cnt  output  CNT_W  counts completed output handshakes.

Function
REQ-014 A handshake occurs on an edge where valid and ready are both 1; there is no other transfer condition.
REQ-015 Lane k of a result SHALL equal the FIPS-197 S-box of input lane k (in_inv=0) or the inverse S-box (in_inv=1); lanes are independent.
REQ-016 The forward S-box and the inverse S-box are each a 256-entry constant table, replicated once per lane.
REQ-017 The datapath is a two-stage elastic pipeline: S1 registers the input bytes and the mode; S2 registers the table output and the mode.
REQ-018 With no backpressure, the latency from input handshake to out_valid is exactly 2 cycles, and throughput is one transfer per cycle.
REQ-019 Advance conditions: adv2 = !s2_valid | out_ready; adv1 = !s1_valid | adv2; in_ready = adv1, decoded combinationally from registered state and out_ready.
REQ-020 out_valid = s2_valid; out_data and out_inv SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 in_ready SHALL NOT depend combinationally on in_valid.
REQ-022 When S1 and S2 are both full and out_ready=0, in_ready is 0 and no data is lost or overwritten.
REQ-023 Simultaneous input and output handshakes in the same cycle SHALL keep the pipeline occupancy unchanged.
REQ-024 Transfers leave in acceptance order; mixed modes in consecutive transfers are processed correctly, each with its own mode bit.
REQ-025 xfer_cnt increments by 1 on each output handshake and wraps from 2^CNT_W-1 to 0.
REQ-026 Register contents are don't-care while the corresponding stage valid bit is 0, but out_data SHALL never carry X onto the port after reset.

Reset
REQ-027 While rst=1, s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_inv=0, xfer_cnt=0, and in_ready=1 from the first cycle after reset.
REQ-028 Reset asserted mid-operation discards all in-flight transfers; after release, no stale result appears on out_valid.
REQ-029 An input handshake offered in a cycle where rst=1 is not captured.

Verification
REQ-030 LANES=4, out_ready=1, in_inv=0, in_data=32'hFF53_0100 -> 2 cycles later out_valid=1, out_data=32'h16ED_7C63, xfer_cnt=1.
REQ-031 Same bench with in_inv=1 and in_data=32'h16ED_7C63 -> out_data=32'hFF53_0100 and out_inv=1 after 2 cycles.
REQ-032 Stream 256 forward transfers of inputs 00..FF (all lanes equal), then stream the results back in inverse mode, with random out_ready -> first pass matches the golden table, second pass returns the original bytes, ordering is preserved, and xfer_cnt=512.
REQ-033 Hold out_ready=0 while in_valid=1 -> exactly 2 transfers are accepted, then in_ready=0 and out_data holds stable; raising out_ready drains both results in order with no loss.
REQ-034 Assert rst for 1 cycle with both stages full -> out_valid=0 on the next cycle, xfer_cnt=0, in_ready=1, and no old data is ever emitted.
REQ-035 CNT_W=4: 17 completed transfers -> xfer_cnt=1 (wrap), and LANES=1 builds and passes REQ-030 using lane 0 only (00->63).
